// File: rtl/fp16_pkg.sv
// Shared FP16 constants and types for the adder stream controller.
// Widths and latency here must match the external fpadder.
package fp16_pkg;

    localparam int FP16_W = 16;
    localparam int ADD_LATENCY = 4;
    localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;
    localparam int FP16_SIGN_BIT = 15;

    typedef logic [FP16_W-1:0] fp16_t;

endpackage

// File: rtl/fp16_result_fifo.sv
// Result FIFO with first-word-fall-through head.
// Head reads as +0 whenever the FIFO is empty.
module fp16_result_fifo
    import fp16_pkg::*;
#(
    parameter int W     = FP16_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    assign head  = empty ? W'(FP16_POS_ZERO) : mem[rp];
    assign level = cnt;

endmodule

// File: rtl/fp16_add_stream_ctrl.sv
// Issue/collect controller around a free-running pipelined FP16 adder.
// Issue is credit-limited so every capture finds room in the FIFO.
module fp16_add_stream_ctrl
    import fp16_pkg::*;
#(
    parameter int W       = FP16_W,
    parameter int LATENCY = ADD_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_a,
    input  logic [W-1:0]            in_b,
    output logic [W-1:0]            add_a,
    output logic [W-1:0]            add_b,
    input  logic [W-1:0]            add_c,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_c,
    output logic [$clog2(DEPTH):0]  inflight,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [LATENCY:0] tag;
    logic             rdy_q;
    logic             accept;
    logic             push;
    logic             pop;
    logic [CW-1:0]    busy;
    logic [CW-1:0]    fill;
    logic [CW:0]      used;

    assign accept = in_valid & in_ready;
    assign push   = tag[LATENCY];
    assign pop    = out_valid & out_ready;

    always_comb begin
        busy = '0;
        for (int i = 0; i <= LATENCY; i++) begin
            busy = busy + CW'(tag[i]);
        end
    end

    // Credits cover both in-flight ops and queued results.
    assign used     = {1'b0, busy} + {1'b0, fill};
    assign in_ready = rdy_q & (used < (CW+1)'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a <= W'(FP16_POS_ZERO);
            add_b <= W'(FP16_POS_ZERO);
            tag   <= '0;
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            tag   <= {tag[LATENCY-1:0], accept};
            if (accept) begin
                add_a <= in_a;
                add_b <= in_b;
            end
        end
    end

    fp16_result_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (add_c),
        .pop   (pop),
        .head  (out_c),
        .level (fill)
    );

    assign out_valid = (fill != '0);
    assign inflight  = busy;
    assign level     = fill;

endmodule

// File: tb/tb_fp16_add_stream_ctrl.sv
// Directed bench for fp16_add_stream_ctrl with a 4-stage adder model.
// The adder model returns hand-computed FP16 sums for the test vectors.
module tb_fp16_add_stream_ctrl;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic [W-1:0]  add_c;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_c;
    logic [CW-1:0] inflight;
    logic [CW-1:0] level;

    logic [W-1:0]  pipe [4];

    int total = 0;
    int bad   = 0;

    logic [W-1:0] s_a   [4] = '{16'h5630, 16'hD1A0, 16'hDC6C, 16'h0000};
    logic [W-1:0] s_b   [4] = '{16'hD590, 16'h54F0, 16'hD420, 16'hD750};
    logic [W-1:0] s_exp [4] = '{16'h4900, 16'h5040, 16'hDD74, 16'hD750};

    logic [W-1:0] z_a   [3] = '{16'h0000, 16'hD6E2, 16'h56EE};
    logic [W-1:0] z_b   [3] = '{16'h0000, 16'h563E, 16'h5632};
    logic [W-1:0] z_exp [3] = '{16'h0000, 16'hC920, 16'h5A90};

    logic [W-1:0] bp_a   [6] = '{16'h5620, 16'h5630, 16'hD1A0,
                                 16'hDC6C, 16'h0000, 16'hD6E2};
    logic [W-1:0] bp_b   [6] = '{16'h5948, 16'hD590, 16'h54F0,
                                 16'hD420, 16'hD750, 16'h563E};
    logic [W-1:0] bp_exp [6] = '{16'h5C2C, 16'h4900, 16'h5040,
                                 16'hDD74, 16'hD750, 16'hC920};

    always #5 clk = ~clk;

    fp16_add_stream_ctrl #(
        .W       (W),
        .LATENCY (4),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_c     (add_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .inflight  (inflight),
        .level     (level)
    );

    function automatic logic [W-1:0] fadd(input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case ({a, b})
            32'h5620_5948: return 16'h5C2C;
            32'h5630_D590: return 16'h4900;
            32'hD1A0_54F0: return 16'h5040;
            32'hDC6C_D420: return 16'hDD74;
            32'h0000_D750: return 16'hD750;
            32'h0000_0000: return 16'h0000;
            32'hD6E2_563E: return 16'hC920;
            32'h56EE_5632: return 16'h5A90;
            default:       return a ^ b;
        endcase
    endfunction

    // Free-running adder: C matches A/B four edges after they change.
    always @(posedge clk) begin
        pipe[0] <= fadd(add_a, add_b);
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign add_c = pipe[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (out_c !== 16'h0000) begin bad++; $display("FAIL rst_out_c got=%h want=0000", out_c); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level got=%0d want=0", level); end
        total++; if (inflight !== 3'd0) begin bad++; $display("FAIL rst_inflight got=%0d want=0", inflight); end
        total++; if (add_a !== 16'h0 || add_b !== 16'h0) begin bad++; $display("FAIL rst_add got=%h/%h want=0000/0000", add_a, add_b); end
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b want=0", in_ready); end
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", in_ready); end
    endtask

    task automatic test_single();
        int n;
        out_ready = 1'b1;
        in_a = 16'h5620;
        in_b = 16'h5948;
        in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (add_a !== 16'h5620 || add_b !== 16'h5948) begin bad++; $display("FAIL single_add got=%h/%h want=5620/5948", add_a, add_b); end
        total++; if (inflight !== 3'd1) begin bad++; $display("FAIL single_inflight got=%0d want=1", inflight); end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n != 5) begin bad++; $display("FAIL single_latency got=%0d want=5", n); end
        total++; if (out_c !== 16'h5C2C) begin bad++; $display("FAIL single_sum got=%h want=5C2C", out_c); end
        tick();
        total++; if (level !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0d/%b want=0/0", level, out_valid); end
    endtask

    task automatic test_streaming();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = s_a[i];
            in_b = s_b[i];
            in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n != 2) begin bad++; $display("FAIL stream_first got=%0d want=2", n); end
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1 || out_c !== s_exp[i]) begin bad++; $display("FAIL stream_out[%0d] got=%b/%h want=1/%h", i, out_valid, out_c, s_exp[i]); end
            tick();
        end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL stream_level got=%0d want=0", level); end
    endtask

    task automatic test_backpressure();
        int  idx = 0;
        int  acc = 0;
        int  rx  = 0;
        int  n   = 0;
        bit  first = 1'b1;
        bit  acc_now;
        bit  pop_now;
        out_ready = 1'b0;
        repeat (10) begin
            if (idx < 6) begin
                in_valid = 1'b1;
                in_a = bp_a[idx];
                in_b = bp_b[idx];
            end
            if (in_ready === 1'b1) begin idx++; acc++; end
            tick();
        end
        total++; if (acc != DEPTH) begin bad++; $display("FAIL bp_accepts got=%0d want=4", acc); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b want=0", in_ready); end
        total++; if (int'(inflight) + int'(level) != DEPTH) begin bad++; $display("FAIL bp_credit got=%0d want=4", int'(inflight) + int'(level)); end
        total++; if (level !== 3'd4) begin bad++; $display("FAIL bp_level got=%0d want=4", level); end
        total++; if (out_c !== bp_exp[0]) begin bad++; $display("FAIL bp_head got=%h want=%h", out_c, bp_exp[0]); end
        out_ready = 1'b1;
        while (rx < 6 && n < 60) begin
            if (idx < 6) begin
                in_valid = 1'b1;
                in_a = bp_a[idx];
                in_b = bp_b[idx];
            end else begin
                in_valid = 1'b0;
            end
            acc_now = (in_ready === 1'b1) && in_valid;
            pop_now = (out_valid === 1'b1);
            if (pop_now) begin
                total++; if (out_c !== bp_exp[rx]) begin bad++; $display("FAIL bp_out[%0d] got=%h want=%h", rx, out_c, bp_exp[rx]); end
                rx++;
            end
            if (acc_now) idx++;
            tick();
            n++;
            if (pop_now && first) begin
                first = 1'b0;
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_credit_back got=%b want=1", in_ready); end
            end
        end
        in_valid = 1'b0;
        total++; if (rx != 6 || idx != 6) begin bad++; $display("FAIL bp_complete got=%0d/%0d want=6/6", rx, idx); end
    endtask

    task automatic test_zero();
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = z_a[i];
            in_b = z_b[i];
            in_valid = 1'b1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL zero_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        for (int i = 0; i < 3; i++) begin
            total++; if (out_valid !== 1'b1 || out_c !== z_exp[i]) begin bad++; $display("FAIL zero_out[%0d] got=%b/%h want=1/%h", i, out_valid, out_c, z_exp[i]); end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int rx = 1;
        int n  = 0;
        out_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            in_valid = (c == 1 || c == 2 || c == 4);
            if (c == 1) begin in_a = s_a[0]; in_b = s_b[0]; end
            if (c == 2) begin in_a = s_a[1]; in_b = s_b[1]; end
            if (c == 4) begin in_a = s_a[2]; in_b = s_b[2]; end
            tick();
        end
        total++; if (level !== 3'd2 || inflight !== 3'd1) begin bad++; $display("FAIL sim_pre got=%0d/%0d want=2/1", level, inflight); end
        total++; if (out_c !== s_exp[0]) begin bad++; $display("FAIL sim_head0 got=%h want=%h", out_c, s_exp[0]); end
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_a = s_a[3];
        in_b = s_b[3];
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL sim_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        total++; if (level !== 3'd2) begin bad++; $display("FAIL sim_level got=%0d want=2", level); end
        total++; if (out_c !== s_exp[1]) begin bad++; $display("FAIL sim_head1 got=%h want=%h", out_c, s_exp[1]); end
        total++; if (inflight !== 3'd1) begin bad++; $display("FAIL sim_inflight got=%0d want=1", inflight); end
        while (rx < 4 && n < 30) begin
            if (out_valid === 1'b1) begin
                total++; if (out_c !== s_exp[rx]) begin bad++; $display("FAIL sim_out[%0d] got=%h want=%h", rx, out_c, s_exp[rx]); end
                rx++;
            end
            tick();
            n++;
        end
        total++; if (rx != 4) begin bad++; $display("FAIL sim_drain got=%0d want=4", rx); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a = s_a[i];
            in_b = s_b[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || level !== 3'd0) begin bad++; $display("FAIL mid_out got=%b/%0d want=0/0", out_valid, level); end
        total++; if (inflight !== 3'd0 || in_ready !== 1'b0) begin bad++; $display("FAIL mid_ctrl got=%0d/%b want=0/0", inflight, in_ready); end
        total++; if (add_a !== 16'h0 || add_b !== 16'h0) begin bad++; $display("FAIL mid_add got=%h/%h want=0000/0000", add_a, add_b); end
        tick();
        rst = 1'b1;
        repeat (15) begin
            if (out_valid !== 1'b0) seen++;
            tick();
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_stale got=%0d want=0", seen); end
        in_a = 16'h5620;
        in_b = 16'h5948;
        in_valid = 1'b1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin tick(); n++; end
        total++; if (n != 5 || out_c !== 16'h5C2C) begin bad++; $display("FAIL mid_new got=%0d/%h want=5/5C2C", n, out_c); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_zero();
        test_simultaneous();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
